frac_tick_gen: RTL and testbench

- Multi-channel fractional-N sample-rate generator; successor to the integer clock divider.
- Each channel runs a phase accumulator clocked by the system clock. It emits a one-cycle tick strobe for use as a clock enable, not a derived clock, plus a ~50% square output.
- Per-channel increment is runtime-programmable through a valid/ready config port. Updates apply glitch-free at the next accumulator wrap.
- Sits between the system clock and the FIR/audio sample pipelines; one channel per sample domain, e.g. 48 kHz and 44.1 kHz.

---
 rtl/frac_tick_gen_if.sv | 16 +
 rtl/frac_tick_gen.sv | 125 ++++++++++++
 tb/tb_frac_tick_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_tick_gen_if.sv
// Config port bundle for frac_tick_gen: valid/ready handshake carrying a
// target channel and a new phase increment.
interface frac_tick_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_valid, output cfg_ch, output cfg_inc, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_inc, output cfg_ready);
endinterface

// File: rtl/frac_tick_gen.sv
// Multi-channel fractional-N tick generator: per-channel phase accumulators with
// glitch-free increment updates at wrap. Optional per-channel tick counters: FRAC_TICK_GEN_CNT_EN.
module frac_tick_gen #(
    parameter int NUM_CH     = 2,
    parameter int ACC_W      = 32,
    parameter int CLK_HZ     = 12_000_000,
    parameter int DESIRED_HZ = 48_000,
    parameter logic [ACC_W-1:0] INC_DEFAULT =
        ACC_W'((64'(DESIRED_HZ) << ACC_W) / 64'(CLK_HZ))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              align,
    frac_tick_gen_if.slave    cfg,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pending
`ifdef FRAC_TICK_GEN_CNT_EN
    ,
    output logic [NUM_CH*16-1:0] tick_cnt
`endif
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PAD_W = 1 << CH_W;

    // Out-of-range channel numbers see a zero pending bit, so they are accepted and dropped.
    logic [PAD_W-1:0] pend_pad;
    assign pend_pad      = PAD_W'(pending);
    assign cfg.cfg_ready = ~pend_pad[cfg.cfg_ch];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
            logic [ACC_W-1:0] acc_q, acc_d;
            logic [ACC_W-1:0] inc_q, inc_d;
            logic [ACC_W-1:0] shadow_q, shadow_d;
            logic             tick_q, tick_d;
            logic             sq_q, sq_d;
            logic             pend_q, pend_d;
            logic [ACC_W:0]   sum;
            logic             take;

            assign sum  = {1'b0, acc_q} + {1'b0, inc_q};
            assign take = cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_ch == CH_W'(gi));

            always_comb begin
                acc_d    = acc_q;
                inc_d    = inc_q;
                shadow_d = shadow_q;
                tick_d   = 1'b0;
                sq_d     = sq_q;
                pend_d   = pend_q;
                if (align) begin
                    acc_d = '0;
                    sq_d  = 1'b0;
                    if (pend_q) begin
                        inc_d  = shadow_q;
                        pend_d = 1'b0;
                    end
                end else if (en[gi]) begin
                    acc_d  = sum[ACC_W-1:0];
                    tick_d = sum[ACC_W];
                    sq_d   = sum[ACC_W-1];
                    // The carrying cycle itself still used the old increment.
                    if (pend_q && sum[ACC_W]) begin
                        inc_d  = shadow_q;
                        pend_d = 1'b0;
                    end
                end else if (pend_q) begin
                    inc_d  = shadow_q;
                    pend_d = 1'b0;
                end
                // A fresh transfer only ever lands on a non-pending channel, so it never races an apply.
                if (take) begin
                    shadow_d = cfg.cfg_inc;
                    pend_d   = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q    <= '0;
                    inc_q    <= INC_DEFAULT;
                    shadow_q <= INC_DEFAULT;
                    tick_q   <= 1'b0;
                    sq_q     <= 1'b0;
                    pend_q   <= 1'b0;
                end else begin
                    acc_q    <= acc_d;
                    inc_q    <= inc_d;
                    shadow_q <= shadow_d;
                    tick_q   <= tick_d;
                    sq_q     <= sq_d;
                    pend_q   <= pend_d;
                end
            end

            assign tick[gi]    = tick_q;
            assign sq[gi]      = sq_q;
            assign pending[gi] = pend_q;

`ifdef FRAC_TICK_GEN_CNT_EN
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q + {15'd0, tick_q};
                if (align) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick_cnt[16*gi +: 16] = cnt_q;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_frac_tick_gen.sv
// Directed + randomized bench for frac_tick_gen (ACC_W=8, NUM_CH=2) against a
// cycle-level arithmetic reference model.
module tb_frac_tick_gen;
    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int CLK = 1_000_000;
    localparam int DES = 100_000;
    localparam int MOD = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           align;
    logic [NCH-1:0] tick, sq, pending;
`ifdef FRAC_TICK_GEN_CNT_EN
    logic [NCH*16-1:0] tick_cnt;
`endif

    frac_tick_gen_if #(.NUM_CH(NCH), .ACC_W(AW)) cif ();

    frac_tick_gen #(.NUM_CH(NCH), .ACC_W(AW), .CLK_HZ(CLK), .DESIRED_HZ(DES)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .align   (align),
        .cfg     (cif.slave),
        .tick    (tick),
        .sq      (sq),
        .pending (pending)
`ifdef FRAC_TICK_GEN_CNT_EN
        ,
        .tick_cnt(tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_def;
    int m_acc[NCH], m_inc[NCH], m_sh[NCH], m_pend[NCH];
    int m_tick[NCH], m_sq[NCH], m_cnt[NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_ready();
        int ch = int'(cif.cfg_ch);
        return (ch < NCH) ? int'(m_pend[ch] == 0) : 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_inc[c] = exp_def; m_sh[c] = exp_def; m_pend[c] = 0;
            m_tick[c] = 0; m_sq[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // Next state from the behavioural rules, using the inputs currently applied.
    task automatic model_next();
        int rdy;
        int s;
        bit take;
        rdy = model_ready();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            take = cif.cfg_valid && (rdy != 0) && (int'(cif.cfg_ch) == c);
            m_cnt[c] = align ? 0 : (m_cnt[c] + m_tick[c]) % 65536;
            if (align) begin
                m_acc[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
                if (m_pend[c] != 0) begin m_inc[c] = m_sh[c]; m_pend[c] = 0; end
            end else if (en[c]) begin
                s = m_acc[c] + m_inc[c];
                m_acc[c]  = s % MOD;
                m_tick[c] = int'(s >= MOD);
                m_sq[c]   = int'(m_acc[c] >= MOD / 2);
                if (m_pend[c] != 0 && s >= MOD) begin m_inc[c] = m_sh[c]; m_pend[c] = 0; end
            end else begin
                m_tick[c] = 0;
                if (m_pend[c] != 0) begin m_inc[c] = m_sh[c]; m_pend[c] = 0; end
            end
            if (take) begin m_sh[c] = int'(cif.cfg_inc); m_pend[c] = 1; end
        end
    endtask

    task automatic step();
        #1;
        chk("cfg_ready", cif.cfg_ready, model_ready());
        model_next();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("tick[%0d]", c), tick[c], m_tick[c]);
            chk($sformatf("sq[%0d]", c), sq[c], m_sq[c]);
            chk($sformatf("pending[%0d]", c), pending[c], m_pend[c]);
`ifdef FRAC_TICK_GEN_CNT_EN
            chk($sformatf("tick_cnt[%0d]", c), tick_cnt[16*c +: 16], m_cnt[c]);
`endif
        end
    endtask

    task automatic run_until_tick(input int c, input int max, output int n);
        n = 0;
        for (int k = 0; k < max; k++) begin
            step();
            n++;
            if (tick[c] === 1'b1) return;
        end
        chk("tick_timeout", tick[c], 1);
    endtask

    task automatic send_cfg(input int ch, input int inc);
        cif.cfg_valid = 1'b1;
        cif.cfg_ch    = ch[0:0];
        cif.cfg_inc   = inc[AW-1:0];
        step();
        cif.cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int cnt1;
        int prev;
        bit found;
        exp_def = int'((longint'(DES) * MOD) / CLK);
        rst = 1'b1; en = '0; align = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_inc = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state
        chk("rst_tick", tick, 0);
        chk("rst_sq", sq, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready", cif.cfg_ready, 1);

        // Reset increment: first wrap after ceil(2^AW / INC_DEFAULT) cycles
        en = 2'b11;
        run_until_tick(0, 40, n);
        chk("default_first_tick", n, (MOD + exp_def - 1) / exp_def);

        // Program ch0=64, ch1=96 while stopped, then align and run
        en = 2'b00;
        send_cfg(0, 64);
        send_cfg(1, 96);
        step();
        align = 1'b1;
        step();
        align = 1'b0;
        chk("prog_pending", pending, 0);
        en = 2'b11;
        cnt1 = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            chk("inc64_tick", tick[0], int'(i % 4 == 0));
            chk("inc64_sq", sq[0], int'((64 * i) % 256 >= 128));
            chk("inc96_tick", tick[1], int'((96 * i) / 256 != (96 * (i - 1)) / 256));
            cnt1 += int'(tick[1] === 1'b1);
        end
        chk("inc96_ticks_per_24", cnt1, 9);

        // Reprogram ch0 64 -> 32 between wraps; second request stalls
        step();
        send_cfg(0, 32);
        chk("reprog_pending", pending[0], 1);
        cif.cfg_valid = 1'b1; cif.cfg_ch = 1'b0; cif.cfg_inc = 8'd200;
        #1;
        chk("stall_ready", cif.cfg_ready, 0);
        step();
        chk("stall_pending", pending[0], 1);
        cif.cfg_valid = 1'b0;
        step();
        chk("reprog_old_tick", tick[0], 1);
        chk("reprog_applied", pending[0], 0);
        run_until_tick(0, 20, n);
        chk("reprog_new_spacing", n, 8);

        // Transfer coincident with a carry waits for the following wrap
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_acc[0] + m_inc[0] >= MOD) found = 1'b1;
            else step();
        end
        chk("coinc_search", found, 1);
        send_cfg(0, 64);
        chk("coinc_tick", tick[0], 1);
        chk("coinc_pending", pending[0], 1);
        run_until_tick(0, 20, n);
        chk("coinc_old_spacing", n, 8);
        chk("coinc_applied", pending[0], 0);
        run_until_tick(0, 20, n);
        chk("coinc_new_spacing", n, 4);

        // align on a ch0 carry cycle also applies ch1's pending increment
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_acc[0] + m_inc[0] < MOD && m_acc[0] + 2 * m_inc[0] >= MOD) found = 1'b1;
            else step();
        end
        chk("align_search", found, 1);
        send_cfg(1, 64);
        chk("align_pre_pending", pending[1], 1);
        align = 1'b1;
        step();
        align = 1'b0;
        chk("align_tick", tick, 0);
        chk("align_sq", sq, 0);
        chk("align_pending", pending, 0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("sync_tick0", tick[0], int'(i % 4 == 0));
            chk("sync_tick1", tick[1], int'(i % 4 == 0));
        end

        // rst mid-run with ch1 stopped and ch0 holding a pending update
        en = 2'b01;
        repeat (3) step();
        send_cfg(0, 10);
        chk("prerst_pending", pending[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tick", tick, 0);
        chk("midrst_sq", sq, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_ready", cif.cfg_ready, 1);
        en = 2'b11;
        run_until_tick(1, 40, n);
        chk("midrst_default_tick", n, (MOD + exp_def - 1) / exp_def);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            en            = NCH'($urandom_range(0, 3));
            align         = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            cif.cfg_valid = ($urandom_range(0, 2) == 0);
            cif.cfg_ch    = 1'($urandom_range(0, 1));
            cif.cfg_inc   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0; align = 1'b0; cif.cfg_valid = 1'b0;

`ifdef FRAC_TICK_GEN_CNT_EN
        // Counter wrap 0xFFFF -> 0 at maximum tick rate, then cleared by rst
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 2'b00;
        send_cfg(0, 255);
        step();
        en = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 70000 && !found; k++) begin
            prev = m_cnt[0];
            step();
            if (prev == 65535 && m_cnt[0] == 0) begin
                found = 1'b1;
                chk("cnt_wrap", tick_cnt[15:0], 0);
            end
        end
        chk("cnt_wrap_seen", found, 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cnt_rst", tick_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
